// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath widths, MEM stage state and MEM/WB bundle
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0] regbits_t;
  typedef enum logic [1:0] {IDLE, ACCESS, HALTED} memstate_t;
  typedef struct packed {
    logic valid;
    logic halt;
    regbits_t wreg;
    word_t mem_reg;
    word_t npc;
    word_t ext_out;
    logic jaltype;
    logic ldtype;
    logic pc_src;
    logic reg_wen;
    logic jtype;
    logic immtype;
  } wb_t;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs, dcache handshake and the write-back side of the MEM stage
interface mem_stage_if;
  import cpu_types_pkg::*;
  logic ex_valid, ex_dREN, ex_dWEN, ex_ldtype, ex_jaltype, ex_jtype, ex_immtype, ex_PCSrc, ex_Reg_Wen, ex_halt;
  regbits_t ex_wreg;
  word_t ex_aluOut, ex_storeData, ex_npc, ex_extOut;
  logic flush, dhit, dmemREN, dmemWEN, mem_stall, wb_valid, wb_halt, mem_err;
  word_t dmemload, dmemaddr, dmemstore;
  regbits_t wb_wreg;
  word_t wb_memReg, wb_npc, wb_extOut;
  logic wb_jaltype, wb_ldtype, wb_PCSrc, wb_Reg_Wen, wb_jtype, wb_immtype;
  modport mem (
    input ex_valid, ex_dREN, ex_dWEN, ex_ldtype, ex_jaltype, ex_jtype, ex_immtype, ex_PCSrc, ex_Reg_Wen, ex_halt,
    input ex_wreg, ex_aluOut, ex_storeData, ex_npc, ex_extOut, flush, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, wb_valid, wb_halt, mem_err,
    output wb_wreg, wb_memReg, wb_npc, wb_extOut, wb_jaltype, wb_ldtype, wb_PCSrc, wb_Reg_Wen, wb_jtype, wb_immtype
  );
  modport wb (
    input wb_valid, wb_halt, wb_wreg, wb_memReg, wb_npc, wb_extOut,
    input wb_jaltype, wb_ldtype, wb_PCSrc, wb_Reg_Wen, wb_jtype, wb_immtype
  );
endinterface

// File: rtl/mem_stage_mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register; bubble loads an all-zero (invalid) entry
module mem_wb_reg
  import cpu_types_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic bubble,
  input  wb_t  d,
  output wb_t  q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (en) q <= bubble ? '0 : d;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: dcache request FSM feeding the MEM/WB register, with halt and dhit watchdog
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int DHIT_TIMEOUT = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_valid,
  input  logic        ex_dREN,
  input  logic        ex_dWEN,
  input  logic        ex_ldtype,
  input  logic        ex_jaltype,
  input  logic        ex_jtype,
  input  logic        ex_immtype,
  input  logic        ex_PCSrc,
  input  logic        ex_Reg_Wen,
  input  logic        ex_halt,
  input  logic [4:0]  ex_wreg,
  input  logic [31:0] ex_aluOut,
  input  logic [31:0] ex_storeData,
  input  logic [31:0] ex_npc,
  input  logic [31:0] ex_extOut,
  input  logic        flush,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_halt,
  output logic        mem_err,
  output logic [4:0]  wb_wreg,
  output logic [31:0] wb_memReg,
  output logic [31:0] wb_npc,
  output logic [31:0] wb_extOut,
  output logic        wb_jaltype,
  output logic        wb_ldtype,
  output logic        wb_PCSrc,
  output logic        wb_Reg_Wen,
  output logic        wb_jtype,
  output logic        wb_immtype
);
  memstate_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic ren_q, wen_q, is_mem, done, go_access;
  logic [31:0] addr_q, store_q;
  wb_t d, q;
  assign is_mem = ex_valid & (ex_dREN | ex_dWEN);
  always_comb begin
    done = (state == IDLE) ? ex_valid & (~is_mem | dhit) : (state == ACCESS) & dhit;
    go_access = (state == IDLE) ? is_mem & ~dhit : (state == ACCESS) & ~dhit;
    state_n = (done & ~flush & ex_halt) ? HALTED : go_access ? ACCESS : (state == HALTED) ? HALTED : IDLE;
    cnt_n = go_access ? cnt + {7'd0, ~&cnt} : '0;
  end
  // A write wins over a read when both are requested.
  assign dmemREN = ~RST & ((state == IDLE) ? is_mem & ex_dREN & ~ex_dWEN : (state == ACCESS) & ren_q);
  assign dmemWEN = ~RST & ((state == IDLE) ? is_mem & ex_dWEN : (state == ACCESS) & wen_q);
  assign dmemaddr = (state == ACCESS) ? addr_q : ex_aluOut;
  assign dmemstore = (state == ACCESS) ? store_q : ex_storeData;
  assign mem_stall = ~RST & ((state == HALTED) | go_access);
  assign d = '{valid: 1'b1, halt: ex_halt, wreg: ex_wreg,
               mem_reg: ex_ldtype ? dmemload : ex_aluOut, npc: ex_npc, ext_out: ex_extOut,
               jaltype: ex_jaltype, ldtype: ex_ldtype, pc_src: ex_PCSrc, reg_wen: ex_Reg_Wen,
               jtype: ex_jtype, immtype: ex_immtype};
  mem_wb_reg u_wb (
    .clk(CLK), .rst(RST), .en(state != HALTED), .bubble(~done | flush), .d(d), .q(q)
  );
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      mem_err <= 1'b0;
      ren_q <= 1'b0;
      wen_q <= 1'b0;
      addr_q <= '0;
      store_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      mem_err <= mem_err | (DHIT_TIMEOUT != 0 && go_access && cnt_n == 8'(DHIT_TIMEOUT));
      if (state == IDLE) begin
        ren_q <= ex_dREN & ~ex_dWEN;
        wen_q <= ex_dWEN;
        addr_q <= ex_aluOut;
        store_q <= ex_storeData;
      end
    end
  assign wb_valid = q.valid;
  assign wb_halt = q.halt;
  assign wb_wreg = q.wreg;
  assign wb_memReg = q.mem_reg;
  assign wb_npc = q.npc;
  assign wb_extOut = q.ext_out;
  assign wb_jaltype = q.jaltype;
  assign wb_ldtype = q.ldtype;
  assign wb_PCSrc = q.pc_src;
  assign wb_Reg_Wen = q.reg_wen;
  assign wb_jtype = q.jtype;
  assign wb_immtype = q.immtype;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage (DHIT_TIMEOUT=4) against hand-computed values
module tb_mem_stage;
  logic CLK = 1'b0, RST;
  logic ex_valid, ex_dREN, ex_dWEN, ex_ldtype, ex_jaltype, ex_jtype, ex_immtype, ex_PCSrc, ex_Reg_Wen, ex_halt;
  logic [4:0] ex_wreg, wb_wreg;
  logic [31:0] ex_aluOut, ex_storeData, ex_npc, ex_extOut, dmemload, dmemaddr, dmemstore;
  logic flush, dhit, dmemREN, dmemWEN, mem_stall, wb_valid, wb_halt, mem_err;
  logic [31:0] wb_memReg, wb_npc, wb_extOut;
  logic wb_jaltype, wb_ldtype, wb_PCSrc, wb_Reg_Wen, wb_jtype, wb_immtype;
  int checks = 0, errors = 0;
  always #5 CLK = ~CLK;
  mem_stage #(.DHIT_TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN),
    .ex_ldtype(ex_ldtype), .ex_jaltype(ex_jaltype), .ex_jtype(ex_jtype), .ex_immtype(ex_immtype),
    .ex_PCSrc(ex_PCSrc), .ex_Reg_Wen(ex_Reg_Wen), .ex_halt(ex_halt), .ex_wreg(ex_wreg),
    .ex_aluOut(ex_aluOut), .ex_storeData(ex_storeData), .ex_npc(ex_npc), .ex_extOut(ex_extOut),
    .flush(flush), .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall), .wb_valid(wb_valid),
    .wb_halt(wb_halt), .mem_err(mem_err), .wb_wreg(wb_wreg), .wb_memReg(wb_memReg),
    .wb_npc(wb_npc), .wb_extOut(wb_extOut), .wb_jaltype(wb_jaltype), .wb_ldtype(wb_ldtype),
    .wb_PCSrc(wb_PCSrc), .wb_Reg_Wen(wb_Reg_Wen), .wb_jtype(wb_jtype), .wb_immtype(wb_immtype)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic clear_ex();
    {ex_valid, ex_dREN, ex_dWEN, ex_ldtype, ex_jaltype, ex_jtype, ex_immtype, ex_PCSrc, ex_Reg_Wen, ex_halt} = '0;
    ex_wreg = '0;
    ex_aluOut = '0;
    ex_storeData = '0;
    ex_npc = '0;
    ex_extOut = '0;
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic load(input logic [31:0] addr, input logic [4:0] rd);
    clear_ex();
    ex_valid = 1'b1;
    ex_dREN = 1'b1;
    ex_ldtype = 1'b1;
    ex_Reg_Wen = 1'b1;
    ex_aluOut = addr;
    ex_wreg = rd;
  endtask
  initial begin
    RST = 1'b1;
    flush = 1'b0;
    dhit = 1'b0;
    dmemload = '0;
    clear_ex();
    ex_valid = 1'b1;
    ex_dREN = 1'b1;
    tick();
    tick();
    check("rst_ren", {31'd0, dmemREN}, 0);
    check("rst_stall", {31'd0, mem_stall}, 0);
    check("rst_valid", {31'd0, wb_valid}, 0);
    check("rst_err", {31'd0, mem_err}, 0);
    RST = 1'b0;
    clear_ex();
    // ALU op: one-cycle latency, no stall
    ex_valid = 1'b1;
    ex_aluOut = 32'h10;
    ex_wreg = 5'd5;
    ex_Reg_Wen = 1'b1;
    ex_npc = 32'h44;
    ex_extOut = 32'h77;
    #1;
    check("alu_stall", {31'd0, mem_stall}, 0);
    check("alu_ren", {31'd0, dmemREN}, 0);
    tick();
    check("alu_memreg", wb_memReg, 32'h10);
    check("alu_wreg", {27'd0, wb_wreg}, 5);
    check("alu_valid", {31'd0, wb_valid}, 1);
    check("alu_regwen", {31'd0, wb_Reg_Wen}, 1);
    check("alu_npc", wb_npc, 32'h44);
    check("alu_ext", wb_extOut, 32'h77);
    clear_ex();
    tick();
    check("idle_bubble", {31'd0, wb_valid}, 0);
    // Load with dhit on the fourth cycle
    load(32'h200, 5'd7);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ld_ren", {31'd0, dmemREN}, 1);
      check("ld_stall", {31'd0, mem_stall}, 1);
      check("ld_addr", dmemaddr, 32'h200);
      tick();
      check("ld_wait_bubble", {31'd0, wb_valid}, 0);
    end
    dhit = 1'b1;
    dmemload = 32'hDEAD_BEEF;
    #1;
    check("ld_hit_stall", {31'd0, mem_stall}, 0);
    tick();
    dhit = 1'b0;
    clear_ex();
    check("ld_memreg", wb_memReg, 32'hDEAD_BEEF);
    check("ld_valid", {31'd0, wb_valid}, 1);
    check("ld_wreg", {27'd0, wb_wreg}, 7);
    #1;
    check("ld_idle_ren", {31'd0, dmemREN}, 0);
    check("ld_idle_stall", {31'd0, mem_stall}, 0);
    check("ld_no_err", {31'd0, mem_err}, 0);
    // Store with read also set, same-cycle hit
    ex_valid = 1'b1;
    ex_dWEN = 1'b1;
    ex_dREN = 1'b1;
    ex_aluOut = 32'h100;
    ex_storeData = 32'h55;
    dhit = 1'b1;
    #1;
    check("st_wen", {31'd0, dmemWEN}, 1);
    check("st_ren", {31'd0, dmemREN}, 0);
    check("st_addr", dmemaddr, 32'h100);
    check("st_data", dmemstore, 32'h55);
    check("st_stall", {31'd0, mem_stall}, 0);
    tick();
    dhit = 1'b0;
    clear_ex();
    #1;
    check("st_valid", {31'd0, wb_valid}, 1);
    check("st_regwen", {31'd0, wb_Reg_Wen}, 0);
    check("st_wen_off", {31'd0, dmemWEN}, 0);
    // Flush coinciding with dhit in ACCESS
    load(32'h300, 5'd3);
    tick();
    check("fl_access_stall", {31'd0, mem_stall}, 1);
    flush = 1'b1;
    dhit = 1'b1;
    dmemload = 32'h1234;
    #1;
    check("fl_hit_stall", {31'd0, mem_stall}, 0);
    tick();
    flush = 1'b0;
    dhit = 1'b0;
    clear_ex();
    #1;
    check("fl_valid", {31'd0, wb_valid}, 0);
    check("fl_regwen", {31'd0, wb_Reg_Wen}, 0);
    check("fl_idle_ren", {31'd0, dmemREN}, 0);
    check("fl_idle_stall", {31'd0, mem_stall}, 0);
    // Watchdog: mem_err visible from the 4th ACCESS cycle, sticky after completion
    load(32'h400, 5'd4);
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("to_err_c%0d", i), {31'd0, mem_err}, (i >= 4) ? 32'd1 : 32'd0);
      tick();
    end
    dhit = 1'b1;
    dmemload = 32'hCAFE_0001;
    tick();
    dhit = 1'b0;
    clear_ex();
    check("to_memreg", wb_memReg, 32'hCAFE_0001);
    check("to_err_sticky", {31'd0, mem_err}, 1);
    // Halt: frozen, no requests under random inputs
    ex_valid = 1'b1;
    ex_halt = 1'b1;
    ex_Reg_Wen = 1'b1;
    ex_wreg = 5'd9;
    tick();
    check("ht_halt", {31'd0, wb_halt}, 1);
    check("ht_valid", {31'd0, wb_valid}, 1);
    for (int i = 0; i < 20; i++) begin
      {ex_valid, ex_dREN, ex_dWEN, ex_halt, ex_ldtype, flush, dhit} = 7'($urandom);
      ex_wreg = 5'($urandom);
      ex_aluOut = $urandom;
      #1;
      check("ht_ren", {31'd0, dmemREN}, 0);
      check("ht_wen", {31'd0, dmemWEN}, 0);
      check("ht_stall", {31'd0, mem_stall}, 1);
      tick();
      check("ht_wreg_frozen", {27'd0, wb_wreg}, 9);
    end
    ex_valid = 1'b1;
    ex_dREN = 1'b1;
    ex_dWEN = 1'b0;
    RST = 1'b1;
    tick();
    check("rh_halt", {31'd0, wb_halt}, 0);
    check("rh_valid", {31'd0, wb_valid}, 0);
    check("rh_err", {31'd0, mem_err}, 0);
    check("rh_ren", {31'd0, dmemREN}, 0);
    check("rh_stall", {31'd0, mem_stall}, 0);
    check("rh_memreg", wb_memReg, 0);
    RST = 1'b0;
    flush = 1'b0;
    dhit = 1'b0;
    clear_ex();
    ex_valid = 1'b1;
    ex_aluOut = 32'hABCD;
    tick();
    check("post_rst_alu", wb_memReg, 32'hABCD);
    check("post_rst_valid", {31'd0, wb_valid}, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DHIT_TIMEOUT, default 0, giving the max cycles waiting on dhit before mem_err; 0 disables the check.
REQ-002 SHALL have port CLK  in  1  system clock; one clock; all state on rising edge.
REQ-003 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports ex_valid, ex_dREN, ex_dWEN, ex_ldtype, ex_jaltype, ex_jtype, ex_immtype, ex_PCSrc, ex_Reg_Wen, ex_halt  in  1 each  EX/MEM control bundle.
REQ-005 SHALL have ports ex_wreg  in  5 (regbits_t), and ex_aluOut, ex_storeData, ex_npc, ex_extOut  in  32 (word_t)  EX/MEM data.
REQ-006 SHALL have port flush  in  1  load a bubble into MEM/WB.
REQ-007 SHALL have ports dhit  in  1, dmemload  in  32  dcache response.
REQ-008 SHALL have ports dmemREN, dmemWEN  out  1, and dmemaddr, dmemstore  out  32  dcache request.
REQ-009 SHALL have port mem_stall  out  1  freeze IF/ID/EX and EX/MEM.
REQ-010 SHALL have ports wb_valid, wb_halt, mem_err  out  1  status.
REQ-011 SHALL have ports wb_wreg (5), wb_memReg, wb_npc, wb_extOut (32), and wb_jaltype, wb_ldtype, wb_PCSrc, wb_Reg_Wen, wb_jtype, wb_immtype (1)  out  registered write-back bundle.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, HALTED.
REQ-013 IDLE, ex_valid, no dREN/dWEN: SHALL latch the bundle into MEM/WB on the next edge; latency 1; mem_stall=0.
REQ-014 IDLE, ex_valid and (dREN or dWEN): SHALL drive the request combinationally the same cycle; dmemaddr=ex_aluOut; dmemstore=ex_storeData.
REQ-015 If dhit is also 1 that cycle, SHALL latch on that edge and stay in IDLE; otherwise SHALL go to ACCESS with mem_stall=1.
REQ-016 ACCESS: SHALL hold the request stable and keep mem_stall=1; on dhit, SHALL latch into MEM/WB, drop mem_stall combinationally that cycle, and return to IDLE.
REQ-017 wb_memReg SHALL be dmemload (captured at dhit) when ldtype=1, else ex_aluOut.
REQ-018 dREN and dWEN both set SHALL be treated as a store; dmemREN=0.
REQ-019 Any edge not latching a valid instruction (ACCESS without dhit, ex_valid=0) SHALL leave MEM/WB holding a bubble: wb_valid=0, wb_Reg_Wen=0.
REQ-020 flush=1 SHALL make the latched MEM/WB entry a bubble; an access already in ACCESS SHALL run to dhit (store is performed) and its result SHALL be discarded.
REQ-021 flush and dhit in the same cycle: SHALL apply flush (bubble) and return to IDLE.
REQ-022 A latched instruction with ex_halt=1 SHALL set wb_halt=1 and enter HALTED.
REQ-023 HALTED: SHALL issue no requests, hold MEM/WB frozen, and keep mem_stall=1 until RST.
REQ-024 When DHIT_TIMEOUT>0, an 8-bit wait counter SHALL count ACCESS cycles and set sticky mem_err when it reaches DHIT_TIMEOUT; the FSM SHALL continue waiting.

Reset
REQ-025 RST=1 at an edge SHALL set state=IDLE, all wb_* outputs=0, mem_err=0, counter=0.
REQ-026 While RST=1, dmemREN, dmemWEN and mem_stall SHALL be 0.
REQ-027 RST asserted in ACCESS or HALTED SHALL abandon state and return to IDLE on that edge.

Structure
REQ-028 memstate_t (IDLE/ACCESS/HALTED) SHALL live in cpu_types_pkg alongside word_t and regbits_t.
REQ-029 Ports SHALL be grouped into a mem_stage_if interface whose wb side matches the write-back stage inputs.
REQ-030 The MEM/WB register SHALL be a sub-module mem_wb_reg (enable, bubble, bundle in/out); the FSM and request logic SHALL live in mem_stage.

Verification
REQ-031 ALU op: ex_valid=1, aluOut=0x0000_0010, wreg=5, Reg_Wen=1 -> next edge wb_memReg=0x10, wb_wreg=5, wb_valid=1, stall never 1.
REQ-032 Load, dhit after 3 cycles, dmemload=0xDEAD_BEEF -> dmemREN=1 and stall=1 for 3 cycles, then wb_memReg=0xDEADBEEF, state IDLE.
REQ-033 Store to 0x100 with data 0x55 and same-cycle dhit -> dmemWEN=1, dmemaddr=0x100, dmemstore=0x55 for one cycle, stall=0, wb_Reg_Wen=0.
REQ-034 Load in ACCESS, flush=1 with dhit -> wb_valid=0 and wb_Reg_Wen=0 next edge, state IDLE.
REQ-035 halt instruction -> wb_halt=1, then dmemREN/dmemWEN=0 for 20 cycles under any inputs, stall=1; RST -> all outputs 0.
REQ-036 DHIT_TIMEOUT=4, dhit withheld 10 cycles -> mem_err=1 from the 4th ACCESS cycle, stays 1 after completion.
